// File: rtl/dly_pool_sched.sv
// Shared pool of countdown slots that hands out delayed one-cycle pulses to several requesters.
// Outputs decode registered slot state only, so req/dly never reach done/busy combinationally.
module dly_pool_sched #(
    parameter int NREQ  = 4,
    parameter int NSLOT = 2,
    parameter int W     = 8,
    parameter int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] dly,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   busy,
    output logic              ovf,
    output logic [IW-1:0]     ovf_id
);

    logic [NSLOT-1:0] active, nActive;
    logic [IW-1:0]    owner  [NSLOT];
    logic [IW-1:0]    nOwner [NSLOT];
    logic [W-1:0]     cnt    [NSLOT];
    logic [W-1:0]     nCnt   [NSLOT];
    logic             nOvf;
    logic [IW-1:0]    nOvfId;

    // A zero delay behaves like a one-tick delay.
    function automatic logic [W-1:0] loadVal(input logic [W-1:0] d);
        return (d == '0) ? W'(1) : d;
    endfunction

    // Retriggers reload their own slot first; remaining new requests then grab the
    // lowest free slot in ascending requester order. A slot firing this cycle is free.
    always_comb begin
        logic [NSLOT-1:0] taken;
        logic [NREQ-1:0]  retrig;
        logic             got;
        nActive = active;
        nOwner  = owner;
        nCnt    = cnt;
        nOvf    = 1'b0;
        nOvfId  = ovf_id;
        taken   = '0;
        retrig  = '0;
        got     = 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
            if (active[s]) begin
                if (cnt[s] == W'(1)) nActive[s] = 1'b0;
                else                 nCnt[s]    = cnt[s] - W'(1);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            for (int s = 0; s < NSLOT; s++) begin
                if (req[i] && active[s] && owner[s] == IW'(i)) begin
                    nActive[s] = 1'b1;
                    nCnt[s]    = loadVal(dly[i*W +: W]);
                    taken[s]   = 1'b1;
                    retrig[i]  = 1'b1;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !retrig[i]) begin
                got = 1'b0;
                for (int s = 0; s < NSLOT; s++) begin
                    if (!got && !taken[s] && (!active[s] || cnt[s] == W'(1))) begin
                        nActive[s] = 1'b1;
                        nOwner[s]  = IW'(i);
                        nCnt[s]    = loadVal(dly[i*W +: W]);
                        taken[s]   = 1'b1;
                        got        = 1'b1;
                    end
                end
                if (!got && !nOvf) begin
                    nOvf   = 1'b1;
                    nOvfId = IW'(i);
                end
            end
        end
    end

    // Slot state and the overflow flag/id registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= '0;
            ovf    <= 1'b0;
            ovf_id <= '0;
            for (int s = 0; s < NSLOT; s++) begin
                owner[s] <= '0;
                cnt[s]   <= '0;
            end
        end else begin
            active <= nActive;
            ovf    <= nOvf;
            ovf_id <= nOvfId;
            for (int s = 0; s < NSLOT; s++) begin
                owner[s] <= nOwner[s];
                cnt[s]   <= nCnt[s];
            end
        end
    end

    // Per-requester view of the slot pool.
    always_comb begin
        done = '0;
        busy = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if (active[s]) begin
                busy[owner[s]] = 1'b1;
                if (cnt[s] == W'(1)) done[owner[s]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dly_pool_sched.sv
// Self-checking bench for dly_pool_sched: directed table, corner sequences, and random traffic
// compared against a per-requester deadline model.
module tb_dly_pool_sched;

    localparam int NREQ  = 4;
    localparam int NSLOT = 2;
    localparam int W     = 8;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] dly;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   busy;
    logic              ovf;
    logic [1:0]        ovf_id;

    int checks = 0;
    int errors = 0;

    // Model: each requester either owns a pending deadline or not; only slot occupancy count matters.
    bit       own    [NREQ];
    int       fireAt [NREQ];
    int       cyc;
    bit       ovfE;
    logic [1:0] ovfIdE;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] dly;
        logic [3:0]  expDone;
        logic [3:0]  expBusy;
    } vec_t;

    dly_pool_sched #(.NREQ(NREQ), .NSLOT(NSLOT), .W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .dly(dly),
        .done(done), .busy(busy), .ovf(ovf), .ovf_id(ovf_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input int d0, input int d1, input int d2, input int d3);
        return {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
    endfunction

    task automatic expectEq(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREQ; i++) begin
            own[i]    = 1'b0;
            fireAt[i] = 0;
        end
        cyc    = 0;
        ovfE   = 1'b0;
        ovfIdE = '0;
    endtask

    task automatic modelAdvance(input logic [3:0] r, input logic [31:0] d);
        bit wasOwn [NREQ];
        int occ;
        int dv;
        bit dropped;
        occ     = 0;
        dropped = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            wasOwn[i] = own[i];
            if (own[i] && fireAt[i] == cyc) own[i] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++)
            if (own[i] || (r[i] && wasOwn[i])) occ++;
        for (int i = 0; i < NREQ; i++) begin
            dv = int'(d[i*8 +: 8]);
            if (dv == 0) dv = 1;
            if (r[i] && wasOwn[i]) begin
                own[i]    = 1'b1;
                fireAt[i] = cyc + dv;
            end else if (r[i]) begin
                if (occ < NSLOT) begin
                    own[i]    = 1'b1;
                    fireAt[i] = cyc + dv;
                    occ++;
                end else if (!dropped) begin
                    dropped = 1'b1;
                    ovfIdE  = 2'(i);
                end
            end
        end
        ovfE = dropped;
        cyc++;
    endtask

    task automatic checkOutput(input string name);
        logic [3:0] dE, bE;
        for (int i = 0; i < NREQ; i++) begin
            dE[i] = own[i] && fireAt[i] == cyc;
            bE[i] = own[i];
        end
        expectEq(name, {5'b0, done, busy, ovf, ovf_id}, {5'b0, dE, bE, ovfE, ovfIdE});
    endtask

    // Drive one cycle's inputs and stop at the negedge where outputs are checked.
    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        req = r;
        dly = d;
        @(negedge clk);
    endtask

    task automatic finishCycle(input logic [3:0] r, input logic [31:0] d);
        modelAdvance(r, d);
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input string name, input logic [3:0] r, input logic [31:0] d);
        applyStimulus(r, d);
        checkOutput(name);
        finishCycle(r, d);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = '0;
        dly   = '0;
        #1;
        expectEq("resetBusyDone", {8'b0, busy, done}, 16'h0);
        expectEq("resetOvf", {13'b0, ovf, ovf_id}, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        vec_t tbl [6];
        logic [3:0]  r;
        logic [31:0] d;

        tbl[0] = '{4'b0001, pack(3, 0, 0, 0), 4'b0000, 4'b0000};
        tbl[1] = '{4'b0010, pack(0, 0, 0, 0), 4'b0000, 4'b0001};
        tbl[2] = '{4'b0000, pack(0, 0, 0, 0), 4'b0010, 4'b0011};
        tbl[3] = '{4'b0000, pack(0, 0, 0, 0), 4'b0001, 4'b0001};
        tbl[4] = '{4'b0000, pack(0, 0, 0, 0), 4'b0000, 4'b0000};
        tbl[5] = '{4'b0000, pack(0, 0, 0, 0), 4'b0000, 4'b0000};

        reset = 1'b1;
        req   = '0;
        dly   = '0;
        modelReset();
        repeat (2) @(posedge clk);
        doReset();

        // Single delay of 3 plus a zero-delay request against hand-written expectations.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(tbl[k].req, tbl[k].dly);
            expectEq("tableDoneBusy", {8'b0, done, busy}, {8'b0, tbl[k].expDone, tbl[k].expBusy});
            checkOutput("tableModel");
            finishCycle(tbl[k].req, tbl[k].dly);
        end

        // Retrigger: first pulse cancelled, one slot left free for requester 0.
        doReset();
        for (int c = 0; c < 14; c++) begin
            r = 4'b0000;
            d = '0;
            if (c == 0) begin r = 4'b0100; d = pack(0, 0, 10, 0); end
            if (c == 6) begin r = 4'b0100; d = pack(0, 0, 4, 0); end
            if (c == 7) begin r = 4'b0001; d = pack(2, 0, 0, 0); end
            applyStimulus(r, d);
            expectEq("retrigDone2", {15'b0, done[2]}, {15'b0, (c == 10)});
            if (c == 8) expectEq("retrigNoOvf", {15'b0, ovf}, 16'h0);
            checkOutput("retrigModel");
            finishCycle(r, d);
        end

        // Overflow: third simultaneous request dropped.
        doReset();
        for (int c = 0; c < 12; c++) begin
            r = (c == 0) ? 4'b0111 : 4'b0000;
            d = pack(5, 5, 5, 0);
            applyStimulus(r, d);
            if (c == 1) expectEq("ovfPulse", {13'b0, ovf, ovf_id}, 16'h6);
            if (c == 5) expectEq("ovfDone", {12'b0, done}, 16'h3);
            expectEq("ovfNoDone2", {15'b0, done[2]}, 16'h0);
            checkOutput("ovfModel");
            finishCycle(r, d);
        end

        // Slot reuse: both slots fire in cycle 9 and requester 3 takes one of them.
        doReset();
        for (int c = 0; c < 14; c++) begin
            r = 4'b0000;
            d = pack(9, 9, 0, 2);
            if (c == 0) r = 4'b0011;
            if (c == 9) r = 4'b1000;
            applyStimulus(r, d);
            if (c == 10) expectEq("reuseNoOvf", {15'b0, ovf}, 16'h0);
            if (c == 11) expectEq("reuseDone3", {12'b0, done}, 16'h8);
            checkOutput("reuseModel");
            finishCycle(r, d);
        end

        // Reset mid-count discards the pending pulse.
        doReset();
        runCycle("rstSetup", 4'b0001, pack(20, 0, 0, 0));
        for (int c = 1; c < 4; c++) runCycle("rstCount", 4'b0000, '0);
        doReset();
        for (int c = 0; c < 40; c++) begin
            applyStimulus(4'b0000, '0);
            expectEq("rstNoDone", {8'b0, done, busy}, 16'h0);
            finishCycle(4'b0000, '0);
        end

        // Random traffic against the model.
        doReset();
        for (int c = 0; c < 400; c++) begin
            r = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            d = pack($urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 12), $urandom_range(0, 12));
            runCycle("random", r, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
